// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// imm_gen_pipe : RISC-V immediate generator with 1-cycle registered output
//                and a two-entry valid/ready skid buffer.
// Revision     : 1.0
// ------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       Imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int         SH_W   = (XLEN == 64) ? 6 : 5;
  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_U  = 3'b011;
  localparam logic [2:0] SRC_J  = 3'b100;
  localparam logic [2:0] SRC_Z  = 3'b101;
  localparam logic [2:0] SRC_SH = 3'b110;

  logic [31:0]      imm32;
  logic             sext_bit;
  logic             illegal;
  logic [XLEN-1:0]  new_imm;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  logic             in_fire;
  logic             out_fire;
  logic             out_valid_n;
  logic             skid_valid_n;
  logic             ld_out_skid;
  logic             ld_out_in;
  logic             ld_skid_in;

  // Opcode bits never feed an immediate; sext_bit is dead in the 32-bit build.
  logic unused_bits;
  assign unused_bits = ^{inst[6:0], sext_bit};

  // Low 32 bits of every format; sext_bit extends the signed ones past bit 31.
  always_comb begin
    imm32    = '0;
    sext_bit = 1'b0;
    illegal  = 1'b0;
    case (Imm_src)
      SRC_I: begin
        imm32    = {{20{inst[31]}}, inst[31:20]};
        sext_bit = inst[31];
      end
      SRC_S: begin
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        sext_bit = inst[31];
      end
      SRC_B: begin
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        sext_bit = inst[31];
      end
      SRC_U: begin
        imm32    = {inst[31:12], 12'b0};
        sext_bit = inst[31];
      end
      SRC_J: begin
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        sext_bit = inst[31];
      end
      SRC_Z: begin
        imm32 = {27'b0, inst[19:15]};
      end
      SRC_SH: begin
        imm32[SH_W-1:0] = inst[20 +: SH_W];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN == 64) begin : g_xlen64
      assign new_imm = {{32{sext_bit}}, imm32};
    end else begin : g_xlen32
      assign new_imm = imm32;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    out_valid_n  = out_valid;
    skid_valid_n = skid_valid;
    ld_out_skid  = 1'b0;
    ld_out_in    = 1'b0;
    ld_skid_in   = 1'b0;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!out_valid || out_fire) begin
      if (skid_valid) begin
        ld_out_skid = 1'b1;
        out_valid_n = 1'b1;
        if (in_fire) begin
          ld_skid_in = 1'b1;
        end else begin
          skid_valid_n = 1'b0;
        end
      end else if (in_fire) begin
        ld_out_in   = 1'b1;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (in_fire) begin
      ld_skid_in   = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= !skid_valid_n;
    end
  end

  // Loads are gated by the handshake, so OUT holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_ext  <= '0;
      imm_err  <= 1'b0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_err <= 1'b0;
      skid_tag <= '0;
    end else begin
      if (ld_out_skid) begin
        imm_ext <= skid_imm;
        imm_err <= skid_err;
        out_tag <= skid_tag;
      end else if (ld_out_in) begin
        imm_ext <= new_imm;
        imm_err <= illegal;
        out_tag <= in_tag;
      end
      if (ld_skid_in) begin
        skid_imm <= new_imm;
        skid_err <= illegal;
        skid_tag <= in_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// Bench for imm_gen_pipe: drives a 32-bit and a 64-bit instance side by side
// against an occupancy-queue reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [2:0]  imm_src;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32, tag32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int n_assert = 0;
  int n_fail   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .Imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_ext(imm32), .imm_err(err32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .Imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_ext(imm64), .imm_err(err64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [31:0] tag;
  } ent_t;

  // Model: the block is a 2-deep FIFO; ready while fewer than 2 entries held.
  ent_t q[$];
  bit   m_of, m_if;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      m_of = (q.size() > 0) && out_ready;
      m_if = in_valid && (q.size() < 2);
      if (m_of) void'(q.pop_front());
      if (m_if) q.push_back('{inst, imm_src, in_tag});
    end
  end

  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input int xl);
    longint v;
    case (s)
      3'd0:    v = $signed(i[31:20]);
      3'd1:    v = $signed({i[31:25], i[11:7]});
      3'd2:    v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3:    v = $signed({i[31:12], 12'b0});
      3'd4:    v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd5:    v = longint'(i[19:15]);
      3'd6:    v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
    in_valid = v;
    inst     = i;
    imm_src  = s;
    in_tag   = t;
  endtask

  task automatic drain();
    @(negedge clk);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    #12;
    n_assert++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid32); end
    n_assert++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32); end
    n_assert++; if (imm32 !== 32'h0) begin n_fail++; $display("FAIL reset_imm32: got %h expected 0", imm32); end
    n_assert++; if (err32 !== 1'b0 || tag32 !== 32'h0) begin n_fail++; $display("FAIL reset_err_tag: got %b/%h expected 0/0", err32, tag32); end
    n_assert++; if (imm64 !== 64'h0 || out_valid64 !== 1'b0) begin n_fail++; $display("FAIL reset_64: got %h/%b expected 0/0", imm64, out_valid64); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_i_format();
    @(negedge clk);
    drive(1'b1, 32'hFFF0_0093, 3'd0, 32'h100);
    @(posedge clk); #1;
    n_assert++; if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL i_valid: got %b expected 1", out_valid32); end
    n_assert++; if (imm32 !== 32'hFFFF_FFFF || err32 !== 1'b0) begin n_fail++; $display("FAIL i_imm32: got %h/%b expected ffffffff/0", imm32, err32); end
    n_assert++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL i_imm64: got %h expected ffffffffffffffff", imm64); end
    drain();
  endtask

  task automatic test_b_j_order();
    @(negedge clk);
    drive(1'b1, 32'hFE00_0EE3, 3'd2, 32'h100);
    @(posedge clk); #1;
    n_assert++; if (imm32 !== 32'hFFFF_FFFC || tag32 !== 32'h100) begin n_fail++; $display("FAIL b_imm: got %h tag %h expected fffffffc tag 100", imm32, tag32); end
    n_assert++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL b_imm64: got %h expected fffffffffffffffc", imm64); end
    @(negedge clk);
    drive(1'b1, 32'h0080_006F, 3'd4, 32'h104);
    @(posedge clk); #1;
    n_assert++; if (out_valid32 !== 1'b1 || imm32 !== 32'h8 || tag32 !== 32'h104) begin n_fail++; $display("FAIL j_imm: got v%b %h tag %h expected v1 8 tag 104", out_valid32, imm32, tag32); end
    n_assert++; if (imm64 !== 64'h8) begin n_fail++; $display("FAIL j_imm64: got %h expected 8", imm64); end
    drain();
  endtask

  task automatic test_xlen64();
    @(negedge clk);
    drive(1'b1, 32'h8000_00B7, 3'd3, 32'h20);
    @(posedge clk); #1;
    n_assert++; if (imm64 !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL u_imm64: got %h expected ffffffff80000000", imm64); end
    n_assert++; if (imm32 !== 32'h8000_0000) begin n_fail++; $display("FAIL u_imm32: got %h expected 80000000", imm32); end
    @(negedge clk);
    drive(1'b1, 32'h03F0_D093, 3'd6, 32'h24);
    @(posedge clk); #1;
    n_assert++; if (imm64 !== 64'h3F) begin n_fail++; $display("FAIL sh_imm64: got %h expected 3f", imm64); end
    n_assert++; if (imm32 !== 32'h1F) begin n_fail++; $display("FAIL sh_imm32: got %h expected 1f", imm32); end
    drain();
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    r = $urandom;
    @(negedge clk);
    drive(1'b1, r, 3'd7, 32'h77);
    @(posedge clk); #1;
    n_assert++; if (out_valid32 !== 1'b1 || tag32 !== 32'h77) begin n_fail++; $display("FAIL illegal_xfer: got v%b tag %h expected v1 tag 77", out_valid32, tag32); end
    n_assert++; if (imm32 !== 32'h0 || err32 !== 1'b1) begin n_fail++; $display("FAIL illegal_32: got %h/%b expected 0/1", imm32, err32); end
    n_assert++; if (imm64 !== 64'h0 || err64 !== 1'b1) begin n_fail++; $display("FAIL illegal_64: got %h/%b expected 0/1", imm64, err64); end
    drain();
  endtask

  task automatic test_backpressure();
    int          sent;
    logic        rdy;
    logic [31:0] got[$];
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rdy = in_ready32;
      drive(sent < 4, 32'h0010_0093 + (sent << 20), 3'd0, 32'h200 + 4 * sent);
      @(posedge clk);
      if (in_valid && rdy) sent++;
    end
    #1;
    n_assert++; if (sent != 2 || in_ready32 !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got %0d accepted ready %b expected 2 ready 0", sent, in_ready32); end
    n_assert++; if (out_valid32 !== 1'b1 || tag32 !== 32'h200) begin n_fail++; $display("FAIL bp_hold: got v%b tag %h expected v1 tag 200", out_valid32, tag32); end
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid32) got.push_back(tag32);
      rdy = in_ready32;
      drive(sent < 4, 32'h0010_0093 + (sent << 20), 3'd0, 32'h200 + 4 * sent);
      @(posedge clk);
      if (in_valid && rdy) sent++;
    end
    n_assert++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d entries expected 4", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_assert++; if (got[k] !== 32'h200 + 4 * k) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], 32'h200 + 4 * k); end
    end
    drain();
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5013, 3'd0, 32'h300);
    @(negedge clk);
    drive(1'b1, 32'h2345_6013, 3'd0, 32'h304);
    @(negedge clk);
    n_assert++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL flush_full: got ready %b expected 0", in_ready32); end
    flush = 1'b1;
    drive(1'b1, 32'h3456_7013, 3'd0, 32'h308);
    @(posedge clk); #1;
    n_assert++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_fail++; $display("FAIL flush_32: got v%b r%b expected v0 r1", out_valid32, in_ready32); end
    n_assert++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin n_fail++; $display("FAIL flush_64: got v%b r%b expected v0 r1", out_valid64, in_ready64); end
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_assert++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL flush_quiet[%0d]: got v%b expected 0", c, out_valid32); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF0_0093, 3'd0, 32'hABC);
    @(negedge clk);
    drive(1'b1, 32'h8000_00B7, 3'd3, 32'hABD);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_assert++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_fail++; $display("FAIL areset_vr: got v%b r%b expected v0 r1", out_valid32, in_ready32); end
    n_assert++; if (imm32 !== 32'h0 || err32 !== 1'b0 || tag32 !== 32'h0) begin n_fail++; $display("FAIL areset_data: got %h/%b/%h expected 0/0/0", imm32, err32, tag32); end
    n_assert++; if (imm64 !== 64'h0 || out_valid64 !== 1'b0) begin n_fail++; $display("FAIL areset_64: got %h/%b expected 0/0", imm64, out_valid64); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    @(posedge clk); #1;
    n_assert++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL areset_lost: got v%b expected 0", out_valid32); end
  endtask

  task automatic test_random();
    ent_t        e;
    logic [63:0] r32, r64;
    bit          ev;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0) ^ (c[6] & c[5]);
      drive($urandom_range(0, 2) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
      @(posedge clk); #1;
      ev = (q.size() != 0);
      n_assert++; if (out_valid32 !== ev || out_valid64 !== ev) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b/%b expected %b", c, out_valid32, out_valid64, ev); end
      n_assert++; if (in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b/%b expected %b", c, in_ready32, in_ready64, q.size() < 2); end
      if (ev) begin
        e   = q[0];
        r32 = ref_imm(e.inst, e.src, 32);
        r64 = ref_imm(e.inst, e.src, 64);
        n_assert++; if (imm32 !== r32[31:0] || imm64 !== r64) begin n_fail++; $display("FAIL rnd_imm c%0d src%0d inst %h: got %h/%h expected %h/%h", c, e.src, e.inst, imm32, imm64, r32[31:0], r64); end
        n_assert++; if (err32 !== (e.src == 3'd7) || err64 !== (e.src == 3'd7)) begin n_fail++; $display("FAIL rnd_err c%0d: got %b/%b expected %b", c, err32, err64, e.src == 3'd7); end
        n_assert++; if (tag32 !== e.tag || tag64 !== e.tag) begin n_fail++; $display("FAIL rnd_tag c%0d: got %h/%h expected %h", c, tag32, tag64, e.tag); end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_b_j_order();
    test_xlen64();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
